// File: rtl/mac_acc_scheduler.sv
// Schedules the partial-sum FIFO for output-interleaved MAC accumulation.
// BufferSize outputs accumulate round-robin over NumPasses passes of the product stream.
module mac_acc_scheduler #(
    parameter int DataWidth   = 32,
    parameter int BufferWidth = 2,
    parameter int BufferSize  = 4,
    parameter int PassWidth   = 8
) (
    input  logic                 clk,
    input  logic                 aclr,
    input  logic                 Start,
    input  logic [PassWidth-1:0] NumPasses,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [DataWidth-1:0] InData,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [DataWidth-1:0] OutData,
    output logic                 Busy,
    output logic                 Done,
    output logic                 FifoPush,
    output logic                 FifoPop,
    output logic [DataWidth-1:0] FifoDataIn,
    input  logic [DataWidth-1:0] FifoDataOut,
    input  logic                 FifoEmpty,
    input  logic                 FifoFull
);

    typedef enum logic [1:0] {IDLE, FILL, ACCUM, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [BufferWidth-1:0] elem_q, elem_d;
    logic [PassWidth-1:0]   pass_q, pass_d;
    logic [PassWidth-1:0]   npass_q, npass_d;
    logic                   done_q, done_d;

    logic                   elem_last;
    logic                   in_ready_raw, out_valid_raw, push_raw, pop_raw;

    assign elem_last = (elem_q == BufferWidth'(BufferSize - 1));

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        elem_d        = elem_q;
        pass_d        = pass_q;
        npass_d       = npass_q;
        done_d        = 1'b0;
        in_ready_raw  = 1'b0;
        out_valid_raw = 1'b0;
        push_raw      = 1'b0;
        pop_raw       = 1'b0;
        FifoDataIn    = InData;
        OutData       = FifoDataOut;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    npass_d = (NumPasses == '0) ? PassWidth'(1) : NumPasses;
                    elem_d  = '0;
                    pass_d  = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                in_ready_raw = !FifoFull;
                if (InValid && in_ready_raw) begin
                    push_raw = 1'b1;
                    elem_d   = elem_q + 1'b1;
                    if (elem_last) begin
                        pass_d  = PassWidth'(1);
                        state_d = (npass_q == PassWidth'(1)) ? DRAIN : ACCUM;
                    end
                end
            end
            ACCUM: begin
                // The head partial sum and the new product meet in the same cycle.
                in_ready_raw = !FifoEmpty;
                if (InValid && in_ready_raw) begin
                    pop_raw    = 1'b1;
                    push_raw   = 1'b1;
                    FifoDataIn = FifoDataOut + InData;
                    elem_d     = elem_q + 1'b1;
                    if (elem_last) begin
                        pass_d = pass_q + 1'b1;
                        if (pass_d == npass_q) begin
                            state_d = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                out_valid_raw = !FifoEmpty;
                if (out_valid_raw && OutReady) begin
                    pop_raw = 1'b1;
                    elem_d  = elem_q + 1'b1;
                    if (elem_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset aborts in its own cycle: nothing reaches the FIFO or the consumer.
    assign InReady  = in_ready_raw  && !aclr;
    assign OutValid = out_valid_raw && !aclr;
    assign FifoPush = push_raw      && !aclr;
    assign FifoPop  = pop_raw       && !aclr;
    assign Busy     = (state_q != IDLE) && !aclr;
    assign Done     = done_q && !aclr;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (aclr) begin
            state_q <= IDLE;
            elem_q  <= '0;
            pass_q  <= '0;
            npass_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            pass_q  <= pass_d;
            npass_q <= npass_d;
            done_q  <= done_d;
        end
    end

endmodule
